// File: rtl/huffman_packer.sv
// huffman_packer
//   Packs variable-length codes (1..64 bits, right-justified in `code`) into a
//   continuous MSB-first bit stream and emits it as bytes, one per cycle.
//   When the message's last code has drained, any partial byte is zero-padded
//   and flagged with last_packet.
//
// Ports
//   clk             rising-edge clock
//   n_rst           asynchronous reset, active-high (1 = reset)
//   code_done       code valid; a code is taken on its rising edge while idle
//   last_char       sampled with the code; this code ends the message
//   code[63:0]      code value in code[bits-1:0]
//   bits[6:0]       code length 0..64; larger values are treated as 64
//   input_enable    packer idle and ready for a new code
//   packet_done     one-cycle strobe: compressed_data holds a new byte
//   last_packet     one-cycle strobe marking the final byte of the message
//   compressed_data output byte, first stream bit in bit 7
module huffman_packer (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        code_done,
    input  logic        last_char,
    input  logic [63:0] code,
    input  logic [6:0]  bits,
    output logic        input_enable,
    output logic        packet_done,
    output logic        last_packet,
    output logic [7:0]  compressed_data
);

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t      state;
    logic [70:0] buffer;          // valid bits are buffer[count-1:0], oldest at count-1
    logic [6:0]  count;
    logic        last_flag;
    logic        code_done_prev;
    logic        byte_sent;       // at least one byte emitted since the last accept

    logic [6:0]  bits_eff;
    logic [63:0] code_masked;
    logic [7:0]  pad_byte;
    logic        accept;

    function automatic logic [63:0] len_mask(input logic [6:0] len);
        if (len >= 7'd64) return '1;
        return (64'd1 << len[5:0]) - 64'd1;
    endfunction

    always_comb begin
        bits_eff    = (bits > 7'd64) ? 7'd64 : bits;
        code_masked = code & len_mask(bits_eff);
        // Left-align the 1..7 leftover bits, zero-filling the low end.
        pad_byte    = buffer[7:0] << (4'd8 - count[3:0]);
        accept      = (state == IDLE) && code_done && !code_done_prev;
    end

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            state           <= IDLE;
            buffer          <= '0;
            count           <= '0;
            last_flag       <= 1'b0;
            code_done_prev  <= 1'b0;
            byte_sent       <= 1'b0;
            input_enable    <= 1'b1;
            packet_done     <= 1'b0;
            last_packet     <= 1'b0;
            compressed_data <= 8'h00;
        end else begin
            code_done_prev <= code_done;
            packet_done    <= 1'b0;
            last_packet    <= 1'b0;

            if (state == IDLE) begin
                if (accept) begin
                    buffer       <= (buffer << bits_eff) | {7'd0, code_masked};
                    count        <= count + bits_eff;
                    last_flag    <= last_char;
                    byte_sent    <= 1'b0;
                    state        <= DRAIN;
                    input_enable <= 1'b0;
                end
            end else begin
                if (count >= 7'd8) begin
                    compressed_data <= buffer[count - 7'd1 -: 8];
                    packet_done     <= 1'b1;
                    count           <= count - 7'd8;
                    byte_sent       <= 1'b1;
                    // Message ends exactly on a byte boundary: flag this byte
                    // and leave an empty buffer for the next stream.
                    if (last_flag && count == 7'd8) begin
                        last_packet <= 1'b1;
                        last_flag   <= 1'b0;
                        buffer      <= '0;
                    end
                end else if (!last_flag) begin
                    // Leftover bits stay in the buffer for the next code.
                    state        <= IDLE;
                    input_enable <= 1'b1;
                end else if (count != 7'd0) begin
                    compressed_data <= pad_byte;
                    packet_done     <= 1'b1;
                    last_packet     <= 1'b1;
                    buffer          <= '0;
                    count           <= '0;
                    last_flag       <= 1'b0;
                    state           <= IDLE;
                    input_enable    <= 1'b1;
                end else begin
                    // Empty buffer at end of message: a bare last_packet marker,
                    // unless a byte already carried it.
                    last_packet  <= !byte_sent;
                    last_flag    <= 1'b0;
                    state        <= IDLE;
                    input_enable <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_huffman_packer.sv
module tb_huffman_packer;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        code_done;
    logic        last_char;
    logic [63:0] code;
    logic [6:0]  bits;
    logic        input_enable;
    logic        packet_done;
    logic        last_packet;
    logic [7:0]  compressed_data;

    huffman_packer dut (
        .clk             (clk),
        .n_rst           (n_rst),
        .code_done       (code_done),
        .last_char       (last_char),
        .code            (code),
        .bits            (bits),
        .input_enable    (input_enable),
        .packet_done     (packet_done),
        .last_packet     (last_packet),
        .compressed_data (compressed_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       pd;
        logic       lp;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   fails  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push_byte(input logic [7:0] d, input logic lp);
        exp_t e;
        e.data = d;
        e.pd   = 1'b1;
        e.lp   = lp;
        exp_q.push_back(e);
    endtask

    task automatic push_marker();
        exp_t e;
        e.data = 8'h00;
        e.pd   = 1'b0;
        e.lp   = 1'b1;
        exp_q.push_back(e);
    endtask

    // Present a code for `hold` cycles starting at a falling edge.
    task automatic issue(input logic [63:0] c, input logic [6:0] b, input logic l, input int hold);
        code      = c;
        bits      = b;
        last_char = l;
        code_done = 1'b1;
        repeat (hold) @(negedge clk);
        code_done = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!input_enable && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", input_enable, 1);
        repeat (2) @(negedge clk);
    endtask

    // Monitor: every output strobe must match the next scoreboard entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (packet_done || last_packet) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_output: pd=%0b lp=%0b data=%0h, expected no output (t=%0t)",
                             packet_done, last_packet, compressed_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("packet_done", packet_done, e.pd);
                    check("last_packet", last_packet, e.lp);
                    if (e.pd) check("byte", compressed_data, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_rst     = 1'b1;
        code_done = 1'b0;
        last_char = 1'b0;
        code      = '0;
        bits      = '0;
        repeat (2) @(negedge clk);
        check("rst_input_enable", input_enable, 1);
        check("rst_packet_done", packet_done, 0);
        check("rst_last_packet", last_packet, 0);
        check("rst_data", compressed_data, 8'h00);
        n_rst = 1'b0;
        @(negedge clk);
        check("ie_after_rst", input_enable, 1);

        // 5-bit code held two cycles: no byte, busy for exactly one cycle.
        code      = 64'd17;
        bits      = 7'd5;
        last_char = 1'b0;
        code_done = 1'b1;
        @(negedge clk);
        check("ie_busy", input_enable, 0);
        @(negedge clk);
        check("ie_back", input_enable, 1);
        code_done = 1'b0;
        repeat (2) @(negedge clk);

        push_byte(8'h8C, 0);
        push_byte(8'hAB, 0);
        issue(64'd38269, 7'd16, 1'b0, 1);
        wait_idle();

        // Held three cycles: accepted once.
        push_byte(8'hED, 0);
        push_byte(8'hB5, 0);
        issue(64'd1461, 7'd11, 1'b0, 3);
        wait_idle();

        // Last code leaves one bit: padded final byte.
        push_byte(8'hE7, 0);
        push_byte(8'h80, 1);
        issue(64'd463, 7'd9, 1'b1, 1);
        wait_idle();

        // Fresh stream, oversize length clamps to 64, ends on byte boundary.
        push_byte(8'hFE, 0);
        push_byte(8'hDC, 0);
        push_byte(8'hBA, 0);
        push_byte(8'h98, 0);
        push_byte(8'h76, 0);
        push_byte(8'h54, 0);
        push_byte(8'h32, 0);
        push_byte(8'h10, 1);
        issue(64'hFEDC_BA98_7654_3210, 7'd100, 1'b1, 1);
        wait_idle();

        // A code_done pulse while draining is ignored.
        push_byte(8'h12, 0);
        push_byte(8'h34, 0);
        push_byte(8'h56, 0);
        issue(64'h0000_0000_0012_3456, 7'd24, 1'b0, 1);
        @(negedge clk);
        code      = 64'hFF;
        bits      = 7'd8;
        last_char = 1'b1;
        code_done = 1'b1;
        check("ie_while_drain", input_enable, 0);
        @(negedge clk);
        code_done = 1'b0;
        wait_idle();

        // Zero-length last code on an empty buffer: bare marker only.
        push_marker();
        issue(64'hFFFF, 7'd0, 1'b1, 1);
        wait_idle();

        // Reset mid-drain drops the remaining bytes.
        push_byte(8'hA5, 0);
        issue(64'hA5A5_A5A5_A5A5_A5A5, 7'd64, 1'b0, 1);
        @(negedge clk);
        #1 n_rst = 1'b1;
        #1;
        check("midrst_packet_done", packet_done, 0);
        check("midrst_last_packet", last_packet, 0);
        check("midrst_input_enable", input_enable, 1);
        check("midrst_data", compressed_data, 8'h00);
        @(negedge clk);
        n_rst = 1'b0;
        repeat (12) @(negedge clk);
        check("ie_after_midrst", input_enable, 1);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
